// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, ROM interface and IF/ID pipeline register
// with stall, flush and delayed-branch redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              flush,
  input  logic [31:0]       new_pc,
  input  logic              branch_flag,
  input  logic [31:0]       branch_target,
  output logic              rom_ce,
  output logic [31:0]       rom_addr,
  input  logic [INST_W-1:0] rom_inst,
  output logic [31:0]       id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic              id_valid,
  output logic [31:0]       fetch_cnt
);

  logic [31:0]       r_pc;
  logic              r_ce;
  logic [31:0]       r_id_pc;
  logic [INST_W-1:0] r_id_inst;
  logic              r_id_valid;
  logic [31:0]       r_fetch_cnt;

  logic [31:0]       w_flush_pc;
  logic [31:0]       w_branch_pc;
  logic              w_bubble;
  logic              w_load;

  // Redirect targets are forced word-aligned so pc[1:0] stays 00.
  assign w_flush_pc  = {new_pc[31:2], 2'b00};
  assign w_branch_pc = {branch_target[31:2], 2'b00};

  assign w_bubble = flush || (stall_if && !stall_id);
  assign w_load   = !w_bubble && !stall_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
      r_ce <= 1'b0;
    end else begin
      r_ce <= 1'b1;
      if (r_ce) begin
        if (flush)
          r_pc <= w_flush_pc;
        else if (stall_if)
          r_pc <= r_pc;
        else if (branch_flag)
          r_pc <= w_branch_pc;
        else
          r_pc <= r_pc + 32'd4;
      end
    end
  end

  // IF/ID register; a disabled ROM still produces a bubble rather than stale data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_id_pc     <= '0;
      r_id_inst   <= '0;
      r_id_valid  <= 1'b0;
      r_fetch_cnt <= '0;
    end else if (w_bubble) begin
      r_id_pc    <= '0;
      r_id_inst  <= '0;
      r_id_valid <= 1'b0;
    end else if (w_load) begin
      if (r_ce) begin
        r_id_pc     <= r_pc;
        r_id_inst   <= rom_inst;
        r_id_valid  <= 1'b1;
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end else begin
        r_id_pc    <= '0;
        r_id_inst  <= '0;
        r_id_valid <= 1'b0;
      end
    end
  end

  assign rom_ce    = r_ce;
  assign rom_addr  = r_pc;
  assign id_pc     = r_id_pc;
  assign id_inst   = r_id_inst;
  assign id_valid  = r_id_valid;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: ROM returns word = address, expected values hand-derived.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall_if;
  logic        stall_id;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [31:0] fetch_cnt;

  int total;
  int bad;

  if_stage #(.RESET_PC(32'h0000_0000), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
    .flush(flush), .new_pc(new_pc), .branch_flag(branch_flag),
    .branch_target(branch_target), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .rom_inst(rom_inst), .id_pc(id_pc), .id_inst(id_inst),
    .id_valid(id_valid), .fetch_cnt(fetch_cnt)
  );

  assign rom_inst = rom_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ce, input logic [31:0] pc,
                         input logic [31:0] ipc, input logic [31:0] iinst,
                         input logic vld, input logic [31:0] cnt);
    chk({tag, ".ce"},   {31'd0, rom_ce},   {31'd0, ce});
    chk({tag, ".pc"},   rom_addr,          pc);
    chk({tag, ".idpc"}, id_pc,             ipc);
    chk({tag, ".inst"}, id_inst,           iinst);
    chk({tag, ".vld"},  {31'd0, id_valid}, {31'd0, vld});
    chk({tag, ".cnt"},  fetch_cnt,         cnt);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    stall_if = 1'b0;
    stall_id = 1'b0;
    flush = 1'b0;
    new_pc = '0;
    branch_flag = 1'b0;
    branch_target = '0;

    #12;
    chk_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    #5 rst = 1'b1;

    // Start-up and free-run
    step(); chk_all("start1", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    step(); chk_all("run4",   1'b1, 32'h4, 32'h0, 32'h0, 1'b1, 32'd1);
    step(); chk_all("run8",   1'b1, 32'h8, 32'h4, 32'h4, 1'b1, 32'd2);

    // Branch with delay slot, unaligned target
    branch_flag = 1'b1; branch_target = 32'h0000_0103;
    step(); chk_all("br",     1'b1, 32'h100, 32'h8, 32'h8, 1'b1, 32'd3);
    branch_flag = 1'b0;
    step(); chk_all("br+1",   1'b1, 32'h104, 32'h100, 32'h100, 1'b1, 32'd4);

    branch_flag = 1'b1; branch_target = 32'h0000_0010;
    step(); chk_all("to16",   1'b1, 32'h10, 32'h104, 32'h104, 1'b1, 32'd5);
    branch_flag = 1'b0;

    // Full stall for three cycles, then IF-only stall
    stall_if = 1'b1; stall_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk_all("stall", 1'b1, 32'h10, 32'h104, 32'h104, 1'b1, 32'd5);
    end
    stall_id = 1'b0;
    step(); chk_all("bubble", 1'b1, 32'h10, 32'h0, 32'h0, 1'b0, 32'd5);
    stall_if = 1'b0;
    step(); chk_all("resume", 1'b1, 32'h14, 32'h10, 32'h10, 1'b1, 32'd6);

    // Flush beats stall and branch
    flush = 1'b1; new_pc = 32'h0000_0020; stall_if = 1'b1;
    branch_flag = 1'b1; branch_target = 32'h0000_0200;
    step(); chk_all("flush",  1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 32'd6);
    flush = 1'b0; stall_if = 1'b0; branch_flag = 1'b0;
    step(); chk_all("postfl", 1'b1, 32'h24, 32'h20, 32'h20, 1'b1, 32'd7);

    // Wrap-around of pc
    branch_flag = 1'b1; branch_target = 32'hFFFF_FFFC;
    step(); chk_all("wrap0",  1'b1, 32'hFFFF_FFFC, 32'h24, 32'h24, 1'b1, 32'd8);
    branch_flag = 1'b0;
    step(); chk_all("wrap1",  1'b1, 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 32'd9);
    step(); chk_all("wrap2",  1'b1, 32'h4, 32'h0, 32'h0, 1'b1, 32'd10);

    // Illegal pairing: pc moves, IF/ID holds
    stall_id = 1'b1;
    step(); chk_all("illeg",  1'b1, 32'h8, 32'h0, 32'h0, 1'b1, 32'd10);
    stall_id = 1'b0;

    // Asynchronous reset mid-run
    branch_flag = 1'b1; branch_target = 32'h0000_0040;
    step(); chk_all("to40",   1'b1, 32'h40, 32'h8, 32'h8, 1'b1, 32'd11);
    branch_flag = 1'b0;
    #2 rst = 1'b0;
    #1 chk_all("arst",    1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    #2 rst = 1'b1;
    step(); chk_all("rest1",  1'b1, 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    step(); chk_all("rest2",  1'b1, 32'h4, 32'h0, 32'h0, 1'b1, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
